// File: rtl/monitor_pkg.sv
// monitor_pkg: shared types, ASCII constants and hex helpers for uart_debug_monitor.
//   state_e  - line parser / executor states
//   reply_e  - which byte sequence the reply index walks through
//   hex2nib  - ASCII hex character -> {valid, nibble}
//   nib2hex  - nibble -> lowercase ASCII hex character
package monitor_pkg;

  typedef enum logic [3:0] {
    StCmd0,
    StCmd1,
    StSp1,
    StAddr,
    StData,
    StExec,
    StRdWait,
    StReply,
    StDone
  } state_e;

  // RpCrlf: bare CR line; RpErr: CRLF then "?\r\n"; RpExec: CRLF then execute;
  // RpHex: 8 hex digits of the read word then CRLF.
  typedef enum logic [1:0] {
    RpCrlf,
    RpErr,
    RpExec,
    RpHex
  } reply_e;

  localparam logic [7:0] AsciiCr    = 8'h0D;
  localparam logic [7:0] AsciiLf    = 8'h0A;
  localparam logic [7:0] AsciiSpace = 8'h20;
  localparam logic [7:0] AsciiQmark = 8'h3F;
  localparam logic [7:0] AsciiL     = 8'h6C;
  localparam logic [7:0] AsciiS     = 8'h73;
  localparam logic [7:0] AsciiW     = 8'h77;

  function automatic logic [4:0] hex2nib(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them to 0xa.
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    // 0x57 + 10 = 'a'
    return (n < 4'd10) ? {4'h3, n} : (8'h57 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_debug_monitor.sv
// uart_debug_monitor: parses "lw A\r" / "sw A D\r" lines from a UART byte stream,
// echoes input, performs word reads/writes and replies in lowercase ASCII hex.
// Ports:
//   Clock, Reset            - clock, synchronous active-high reset
//   RxData/RxValid/RxReady  - incoming byte stream (ready/valid)
//   TxData/TxValid/TxReady  - outgoing byte stream (ready/valid)
//   MemAddr/MemRead/MemWrite/MemWData/MemRData - word memory port; MemRData valid
//                             the cycle after MemRead
module uart_debug_monitor
  import monitor_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [7:0]           RxData,
  input  logic                 RxValid,
  output logic                 RxReady,
  output logic [7:0]           TxData,
  output logic                 TxValid,
  input  logic                 TxReady,
  output logic [AddrWidth-1:0] MemAddr,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [31:0]          MemWData,
  input  logic [31:0]          MemRData
);

  state_e                 state_q, state_d;
  reply_e                 mode_q, mode_d;
  logic                   is_sw_q, is_sw_d;
  logic                   err_q, err_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [3:0]             idx_q, idx_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [AddrWidth-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;

  logic                   parsing;
  logic                   rx_fire;
  logic                   tx_fire;
  logic                   line_bad;
  logic [4:0]             nib;
  logic [3:0]             cnt_inc;
  logic [3:0]             idx_nxt;

  function automatic logic [3:0] reply_last(input reply_e m);
    logic [3:0] r;
    unique case (m)
      RpHex:   r = 4'd9;
      RpErr:   r = 4'd4;
      default: r = 4'd1;
    endcase
    return r;
  endfunction

  // Tx byte source for every reply sequence, selected by mode and reply index.
  function automatic logic [7:0] reply_byte(input reply_e m, input logic [3:0] i,
                                            input logic [31:0] w);
    logic [7:0]  b;
    logic [31:0] sh;
    b  = AsciiCr;
    sh = w << {i, 2'b00};
    if (m == RpHex) begin
      if (i < 4'd8)       b = nib2hex(sh[31:28]);
      else if (i == 4'd8) b = AsciiCr;
      else                b = AsciiLf;
    end else if (m == RpErr) begin
      unique case (i)
        4'd0:    b = AsciiCr;
        4'd1:    b = AsciiLf;
        4'd2:    b = AsciiQmark;
        4'd3:    b = AsciiCr;
        default: b = AsciiLf;
      endcase
    end else begin
      b = (i == 4'd0) ? AsciiCr : AsciiLf;
    end
    return b;
  endfunction

  assign parsing = (state_q inside {StCmd0, StCmd1, StSp1, StAddr, StData});
  assign RxReady = parsing && !tx_valid_q && !Reset;
  assign rx_fire = RxValid && RxReady;
  assign tx_fire = tx_valid_q && TxReady;
  assign nib     = hex2nib(RxData);
  assign cnt_inc = (cnt_q == 4'd9) ? 4'd9 : cnt_q + 4'd1;
  assign idx_nxt = idx_q + 4'd1;

  // A line ending here cannot execute: flagged error, or a required field is missing.
  assign line_bad = err_q
                 || (state_q inside {StCmd1, StSp1})
                 || (state_q == StAddr && (cnt_q == 4'd0 || is_sw_q))
                 || (state_q == StData && cnt_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    is_sw_d     = is_sw_q;
    err_d       = err_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (parsing) begin
      if (tx_fire) tx_valid_d = 1'b0;
      if (rx_fire) begin
        if (RxData == AsciiLf) begin
          // discarded silently
        end else if (RxData == AsciiCr) begin
          state_d    = StReply;
          idx_d      = 4'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = AsciiCr;
          if (line_bad)               mode_d = RpErr;
          else if (state_q == StCmd0) mode_d = RpCrlf;
          else                        mode_d = RpExec;
        end else begin
          tx_valid_d = 1'b1;
          tx_data_d  = RxData;
          // Once err is set, bytes are only echoed until CR.
          if (!err_q) begin
            case (state_q)
              StCmd0: begin
                if (RxData == AsciiL) begin
                  is_sw_d = 1'b0;
                  state_d = StCmd1;
                end else if (RxData == AsciiS) begin
                  is_sw_d = 1'b1;
                  state_d = StCmd1;
                end else begin
                  err_d = 1'b1;
                end
              end
              StCmd1: begin
                if (RxData == AsciiW) state_d = StSp1;
                else                  err_d   = 1'b1;
              end
              StSp1: begin
                if (RxData == AsciiSpace) begin
                  state_d = StAddr;
                  cnt_d   = 4'd0;
                end else begin
                  err_d = 1'b1;
                end
              end
              StAddr: begin
                if (nib[4]) begin
                  addr_d = {addr_q[AddrWidth-5:0], nib[3:0]};
                  cnt_d  = cnt_inc;
                  if (cnt_inc == 4'd9) err_d = 1'b1;
                end else if (RxData == AsciiSpace && is_sw_q && cnt_q != 4'd0) begin
                  state_d = StData;
                  cnt_d   = 4'd0;
                end else begin
                  err_d = 1'b1;
                end
              end
              StData: begin
                if (nib[4]) begin
                  data_d = {data_q[27:0], nib[3:0]};
                  cnt_d  = cnt_inc;
                  if (cnt_inc == 4'd9) err_d = 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end else begin
      case (state_q)
        StReply: begin
          if (tx_fire) begin
            if (idx_q == reply_last(mode_q)) begin
              tx_valid_d = 1'b0;
              if (mode_q == RpExec) begin
                // Strobe is registered so it is high exactly while in StExec.
                state_d    = StExec;
                mem_addr_d = {addr_q[AddrWidth-1:2], 2'b00};
                if (is_sw_q) begin
                  mem_write_d = 1'b1;
                  mem_wdata_d = data_q;
                end else begin
                  mem_read_d = 1'b1;
                end
              end else begin
                state_d = StDone;
              end
            end else begin
              idx_d     = idx_nxt;
              tx_data_d = reply_byte(mode_q, idx_nxt, rdata_q);
            end
          end
        end
        StExec: begin
          state_d = is_sw_q ? StDone : StRdWait;
        end
        StRdWait: begin
          rdata_d    = MemRData;
          state_d    = StReply;
          mode_d     = RpHex;
          idx_d      = 4'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = reply_byte(RpHex, 4'd0, MemRData);
        end
        StDone: begin
          state_d = StCmd0;
          err_d   = 1'b0;
          is_sw_d = 1'b0;
          addr_d  = '0;
          data_d  = '0;
          cnt_d   = 4'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StCmd0;
      mode_q      <= RpCrlf;
      is_sw_q     <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      is_sw_q     <= is_sw_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign TxValid  = tx_valid_q;
  assign TxData   = tx_data_q;
  assign MemRead  = mem_read_q;
  assign MemWrite = mem_write_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;

endmodule

// File: tb/tb_uart_debug_monitor.sv
// Directed self-checking bench for uart_debug_monitor.
module tb_uart_debug_monitor;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemWData;
  logic [31:0] MemRData = 32'h0;

  uart_debug_monitor #(.AddrWidth(32)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .RxData   (RxData),
    .RxValid  (RxValid),
    .RxReady  (RxReady),
    .TxData   (TxData),
    .TxValid  (TxValid),
    .TxReady  (TxReady),
    .MemAddr  (MemAddr),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .MemWData (MemWData),
    .MemRData (MemRData)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model and output monitors, all sampling pre-edge values.
  logic [31:0] mem [logic [31:0]];
  logic [7:0]  tx_log [$];
  int          cyc = 0;
  int          last_lf_cyc = 0;
  int          rd_lat = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          both_hi = 0;
  logic [31:0] last_rd_addr = 32'h0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  always @(posedge Clock) begin
    cyc++;
    if (!Reset) begin
      if (TxValid && TxReady) begin
        tx_log.push_back(TxData);
        if (TxData == 8'h0A) last_lf_cyc = cyc;
      end
      if (MemRead && MemWrite) both_hi++;
      if (MemRead) begin
        n_rd++;
        last_rd_addr = MemAddr;
        rd_lat = cyc - last_lf_cyc;
        MemRData <= mem.exists(MemAddr) ? mem[MemAddr] : 32'h0;
      end
      if (MemWrite) begin
        n_wr++;
        last_wr_addr = MemAddr;
        last_wr_data = MemWData;
        mem[MemAddr] = MemWData;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge Clock);
    RxData  = b;
    RxValid = 1'b1;
    while (!RxReady && n < 1000) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 1000) check_eq("rx_accept_timeout", {31'b0, RxReady}, 32'd1);
    @(posedge Clock);
    #1 RxValid = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_tx(input string tag, input string exp);
    int n;
    n = 0;
    while (tx_log.size() < exp.len() && n < 3000) begin
      @(negedge Clock);
      n++;
    end
    repeat (30) @(negedge Clock);
    check_eq({tag, "_len"}, tx_log.size(), exp.len());
    for (int i = 0; i < exp.len() && i < tx_log.size(); i++) begin
      check_eq($sformatf("%s_b%0d", tag, i), {24'h0, tx_log[i]}, {24'h0, exp[i]});
    end
    tx_log.delete();
  endtask

  int          rd0;
  int          wr0;
  int          viol;
  logic [7:0]  held;

  initial begin
    Reset   = 1'b1;
    RxValid = 1'b0;
    RxData  = 8'h00;
    TxReady = 1'b1;
    mem[32'h1000_3000] = 32'hDEAD_BEEF;
    mem[32'h0000_0004] = 32'h0000_0001;
    mem[32'h0000_0000] = 32'h89AB_CDEF;
    mem[32'h0000_0040] = 32'h0123_ABCD;

    // Reset values
    repeat (3) @(negedge Clock);
    check_eq("rst_rxready",  {31'b0, RxReady},  32'd0);
    check_eq("rst_txvalid",  {31'b0, TxValid},  32'd0);
    check_eq("rst_memread",  {31'b0, MemRead},  32'd0);
    check_eq("rst_memwrite", {31'b0, MemWrite}, 32'd0);
    check_eq("rst_txdata",   {24'h0, TxData},   32'd0);
    check_eq("rst_memaddr",  MemAddr,           32'd0);
    check_eq("rst_memwdata", MemWData,          32'd0);
    Reset = 1'b0;
    #1 check_eq("post_rst_rxready", {31'b0, RxReady}, 32'd1);

    // Bare CR: only CRLF, no strobe
    send_line("\r");
    expect_tx("bare_cr", "\r\n");
    check_eq("bare_cr_rd", n_rd, 0);

    // lw with full 8-digit address
    send_line("lw 10003000\r");
    expect_tx("lw1", "lw 10003000\r\ndeadbeef\r\n");
    check_eq("lw1_nrd",   n_rd,         1);
    check_eq("lw1_addr",  last_rd_addr, 32'h1000_3000);
    check_eq("lw1_lat",   rd_lat,       1);
    check_eq("lw1_nwr",   n_wr,         0);

    // sw with mixed-case data, then read back
    send_line("sw 20 CAFEf00d\r");
    expect_tx("sw1", "sw 20 CAFEf00d\r\n");
    check_eq("sw1_nwr",   n_wr,         1);
    check_eq("sw1_addr",  last_wr_addr, 32'h0000_0020);
    check_eq("sw1_data",  last_wr_data, 32'hCAFE_F00D);
    check_eq("sw1_nrd",   n_rd,         1);
    send_line("lw 20\r");
    expect_tx("lw2", "lw 20\r\ncafef00d\r\n");
    check_eq("lw2_addr",  last_rd_addr, 32'h0000_0020);

    // Error lines: 9 digits, bad command
    rd0 = n_rd;
    wr0 = n_wr;
    send_line("lw 123456789\r");
    expect_tx("err9", "lw 123456789\r\n?\r\n");
    send_line("xw 0\r");
    expect_tx("errx", "xw 0\r\n?\r\n");
    send_line("sw 8\r");
    expect_tx("errsw", "sw 8\r\n?\r\n");
    check_eq("err_nrd", n_rd - rd0, 0);
    check_eq("err_nwr", n_wr - wr0, 0);

    // Back-pressure mid-reply
    send_line("lw 40\r");
    viol = 0;
    while (tx_log.size() < 10 && viol < 3000) begin
      @(negedge Clock);
      viol++;
    end
    TxReady = 1'b0;
    check_eq("stall_valid", {31'b0, TxValid}, 32'd1);
    held = TxData;
    viol = 0;
    repeat (50) begin
      @(negedge Clock);
      if (!TxValid || TxData !== held || RxReady) viol++;
    end
    check_eq("stall_stable", viol, 0);
    TxReady = 1'b1;
    expect_tx("stall", "lw 40\r\n0123abcd\r\n");

    // Reset mid-command aborts it
    rd0 = n_rd;
    send_line("lw 7");
    repeat (5) @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    check_eq("midrst_txvalid", {31'b0, TxValid}, 32'd0);
    Reset = 1'b0;
    tx_log.delete();
    send_line("lw 4\r");
    expect_tx("lw4", "lw 4\r\n00000001\r\n");
    check_eq("lw4_nrd",  n_rd - rd0,   1);
    check_eq("lw4_addr", last_rd_addr, 32'h0000_0004);

    // Low address bits cleared; LFs discarded anywhere
    send_line("\nl\nw 3\n\r");
    expect_tx("lw3", "lw 3\r\n89abcdef\r\n");
    check_eq("lw3_addr", last_rd_addr, 32'h0000_0000);

    check_eq("both_strobes", both_hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
